alarm_scheduler: RTL and testbench
==================================

# alarm_scheduler

Multi-slot alarm controller that sits beside the timekeeping counter. It stores NUM_SLOTS programmable alarm times and compares them against the running time once per second. It sequences the ring / snooze / dismiss behaviour through a state machine. Configuration is written through a valid/ready handshake, and everything runs in the single system clock domain, gated by a one-cycle seconds strobe.

## Interface
- NUM_SLOTS, 4: number of alarm slots (2..8); SW = clog2(NUM_SLOTS)
- SNOOZE_MIN, 5: snooze length in minutes (1..30)
- RING_TIMEOUT, 60: seconds of unattended ringing before auto-stop (1..255)
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..3)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse per second; time_* hold the newly reached time in that cycle
- time_hh  in  6  current hour 0..23
- time_mm  in  6  current minute 0..59
- time_ss  in  6  current second 0..59
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_slot  in  SW  slot index to write
- cfg_enable  in  1  slot enable bit written with the time
- cfg_hh / cfg_mm / cfg_ss  in  6 each  alarm time to store
- cfg_err  out  1  one-cycle pulse: write rejected (out-of-range time)
- snooze  in  1  user snooze request, sampled every clk
- dismiss  in  1  user dismiss request, sampled every clk
- alarm  out  1  high while ringing
- active_slot  out  SW  slot that owns the current event
- snooze_count  out  2  snoozes taken in the current event
- missed  out  1  one-cycle pulse on ring timeout

## Operation
- Reset: all slots are disabled with time 00:00:00. State is IDLE. alarm=0, active_slot=0, snooze_count=0, missed=0, cfg_err=0. cfg_ready=1 (combinational, derived from state).
- States: IDLE, RING, SNOOZE.
- IDLE:
  - On sec_tick, all enabled slots are compared in parallel against time_*.
  - On any match, the lowest-index matching slot wins. The FSM goes to RING with active_slot = that slot, snooze_count=0, and ring timer=0.
- RING (alarm=1):
  - dismiss -> IDLE.
  - Otherwise, snooze with snooze_count<MAX_SNOOZE -> SNOOZE. The snooze counter loads SNOOZE_MIN*60 and snooze_count increments.
  - A snooze request at MAX_SNOOZE is ignored; ringing continues.
  - Each sec_tick increments the ring timer. When the timer reaches RING_TIMEOUT, the FSM goes to IDLE and pulses missed.
- SNOOZE (alarm=0):
  - Each sec_tick decrements the snooze counter. The decrement that reaches 0 moves the FSM to RING with the ring timer cleared and snooze_count kept.
  - dismiss -> IDLE. snooze is ignored.
- Simultaneous dismiss and snooze: dismiss wins.
- Matches while in RING or SNOOZE are dropped, not queued.
- Config handshake:
  - cfg_ready=0 only when state≠IDLE and cfg_slot==active_slot. Otherwise cfg_ready=1.
  - On an accepted write with cfg_hh≤23, cfg_mm≤59 and cfg_ss≤59, the slot takes {enable, hh, mm, ss} at the clock edge.
  - On an out-of-range write, the slot is unchanged and cfg_err pulses for 1 cycle.
- A write and a compare in the same cycle: the compare uses the pre-write slot contents.
- Counter widths:
  - Snooze counter: 11 bits (max 1800).
  - Ring timer: 8 bits, saturating, never wraps.
- Midnight wrap (23:59:59 -> 00:00:00) needs no special handling. A slot set to 00:00:00 matches on the tick that lands at 00:00:00.

## Timing
- Match to ring: alarm rises at the clk edge ending the matching sec_tick cycle. It is visible the cycle after sec_tick.
- dismiss/snooze: alarm falls at the edge ending the cycle in which the request is sampled high (1-cycle latency). No sec_tick is required.
- Re-ring: alarm rises exactly SNOOZE_MIN*60 sec_ticks after snooze. It is visible the cycle after the final tick.
- Timeout: alarm falls and missed pulses at the edge ending the RING_TIMEOUT-th sec_tick after entry to RING.
- cfg write: takes effect at the next edge. Back-to-back writes are accepted every cycle.
- Reset mid-operation: outputs return to reset values at the next edge, and all slots clear.

## Test plan
- Slot 1 = 07:30:00, enabled. Drive ticks through 07:29:59 -> 07:30:00. Required: alarm=1 and active_slot=1 in the cycle after the 07:30:00 tick. Assert dismiss for 1 cycle -> alarm=0 next cycle.
- Slots 0 and 2 both = 12:00:00, enabled. Required: active_slot=0 on match. Slot 2 does not re-trigger afterwards.
- Ringing with SNOOZE_MIN=5. Apply snooze -> alarm=0 and snooze_count=1. Required: alarm=1 again after exactly 300 ticks. After 3 snoozes, a 4th snooze leaves alarm=1.
- Ringing with no input. Required: after 60 ticks alarm=0, missed=1 for exactly 1 cycle, and state returns to IDLE.
- Write cfg_hh=24 to slot 3. Required: cfg_err pulses and slot 3 does not fire at 00:xx. While slot 1 rings, a write to slot 1 sees cfg_ready=0, and a write to slot 2 is accepted.
- Assert snooze and dismiss together while ringing -> alarm=0, state IDLE, snooze_count unchanged. Assert reset during SNOOZE -> all outputs are at reset values next cycle, and no later ring occurs.

Source files
------------

// File: rtl/alarm_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_scheduler_if
// Purpose  : Configuration write channel of the alarm scheduler.
//            master drives the write request, slave (the scheduler) answers
//            with cfg_ready and the cfg_err rejection pulse.
// Signals  : cfg_valid, cfg_ready, cfg_slot[SW], cfg_enable,
//            cfg_hh/cfg_mm/cfg_ss[6], cfg_err
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_scheduler_if #(
   parameter int SW = 2
);
   logic          cfg_valid;
   logic          cfg_ready;
   logic [SW-1:0] cfg_slot;
   logic          cfg_enable;
   logic [5:0]    cfg_hh;
   logic [5:0]    cfg_mm;
   logic [5:0]    cfg_ss;
   logic          cfg_err;

   modport master (
      output cfg_valid, cfg_slot, cfg_enable, cfg_hh, cfg_mm, cfg_ss,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_slot, cfg_enable, cfg_hh, cfg_mm, cfg_ss,
      output cfg_ready, cfg_err
   );
endinterface
`default_nettype wire

// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alarm_scheduler
// Purpose  : NUM_SLOTS programmable alarms compared against the running time
//            on every seconds strobe, with ring / snooze / dismiss sequencing
//            and ring auto-timeout.
// Ports    : clk, reset (sync, active-high), sec_tick, time_hh/mm/ss,
//            cfg (alarm_scheduler_if.slave), snooze, dismiss,
//            alarm, active_slot[SW], snooze_count[2], missed
// Revision : 1.0 - initial release
// ============================================================================
module alarm_scheduler #(
   parameter  int NUM_SLOTS    = 4,
   parameter  int SNOOZE_MIN   = 5,
   parameter  int RING_TIMEOUT = 60,
   parameter  int MAX_SNOOZE   = 3,
   localparam int SW           = $clog2(NUM_SLOTS)
) (
   input  wire logic          clk,
   input  wire logic          reset,
   input  wire logic          sec_tick,
   input  wire logic [5:0]    time_hh,
   input  wire logic [5:0]    time_mm,
   input  wire logic [5:0]    time_ss,
   alarm_scheduler_if.slave   cfg,
   input  wire logic          snooze,
   input  wire logic          dismiss,
   output logic               alarm,
   output logic [SW-1:0]      active_slot,
   output logic [1:0]         snooze_count,
   output logic               missed
);

   localparam logic [1:0]  C_MAX_SNOOZE = 2'(MAX_SNOOZE);
   localparam logic [10:0] C_SNOOZE_LD  = 11'(SNOOZE_MIN * 60);
   localparam logic [7:0]  C_TIMEOUT    = 8'(RING_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   state_t        state;
   logic [7:0]    ring_timer;
   logic [10:0]   snooze_cnt;
   logic          cfg_err_r;

   logic          slot_en [NUM_SLOTS];
   logic [5:0]    slot_hh [NUM_SLOTS];
   logic [5:0]    slot_mm [NUM_SLOTS];
   logic [5:0]    slot_ss [NUM_SLOTS];

   logic          hit;
   logic [SW-1:0] hit_idx;
   logic          cfg_ok;
   logic [7:0]    ring_next;

   // Scan high to low so the lowest matching index is the last one written.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (slot_en[i] && slot_hh[i] == time_hh &&
             slot_mm[i] == time_mm && slot_ss[i] == time_ss) begin
            hit     = 1'b1;
            hit_idx = SW'(i);
         end
      end
   end

   // The slot owning a live event is locked against rewrites.
   assign cfg.cfg_ready = !(state != IDLE && cfg.cfg_slot == active_slot);
   assign cfg.cfg_err   = cfg_err_r;
   assign cfg_ok        = (cfg.cfg_hh <= 6'd23) && (cfg.cfg_mm <= 6'd59) &&
                          (cfg.cfg_ss <= 6'd59);
   assign ring_next     = (ring_timer == 8'hFF) ? 8'hFF : ring_timer + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         alarm        <= 1'b0;
         active_slot  <= '0;
         snooze_count <= 2'd0;
         missed       <= 1'b0;
         cfg_err_r    <= 1'b0;
         ring_timer   <= 8'd0;
         snooze_cnt   <= 11'd0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_en[i] <= 1'b0;
            slot_hh[i] <= 6'd0;
            slot_mm[i] <= 6'd0;
            slot_ss[i] <= 6'd0;
         end
      end else begin
         missed    <= 1'b0;
         cfg_err_r <= 1'b0;

         // Slot registers update at this edge; the compare above already
         // used the old contents, giving pre-write semantics.
         if (cfg.cfg_valid && cfg.cfg_ready) begin
            if (!cfg_ok) begin
               cfg_err_r <= 1'b1;
            end else if (int'(cfg.cfg_slot) < NUM_SLOTS) begin
               slot_en[cfg.cfg_slot] <= cfg.cfg_enable;
               slot_hh[cfg.cfg_slot] <= cfg.cfg_hh;
               slot_mm[cfg.cfg_slot] <= cfg.cfg_mm;
               slot_ss[cfg.cfg_slot] <= cfg.cfg_ss;
            end
         end

         case (state)
            IDLE: begin
               if (sec_tick && hit) begin
                  state        <= RING;
                  alarm        <= 1'b1;
                  active_slot  <= hit_idx;
                  snooze_count <= 2'd0;
                  ring_timer   <= 8'd0;
               end
            end
            RING: begin
               if (dismiss) begin
                  state <= IDLE;
                  alarm <= 1'b0;
               end else if (snooze && snooze_count < C_MAX_SNOOZE) begin
                  state        <= SNOOZE;
                  alarm        <= 1'b0;
                  snooze_cnt   <= C_SNOOZE_LD;
                  snooze_count <= snooze_count + 2'd1;
               end else if (sec_tick) begin
                  ring_timer <= ring_next;
                  if (ring_next >= C_TIMEOUT) begin
                     state  <= IDLE;
                     alarm  <= 1'b0;
                     missed <= 1'b1;
                  end
               end
            end
            SNOOZE: begin
               if (dismiss) begin
                  state <= IDLE;
               end else if (sec_tick) begin
                  if (snooze_cnt <= 11'd1) begin
                     state      <= RING;
                     alarm      <= 1'b1;
                     ring_timer <= 8'd0;
                     snooze_cnt <= 11'd0;
                  end else begin
                     snooze_cnt <= snooze_cnt - 11'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               alarm <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_scheduler
// Purpose  : Directed self-checking bench for alarm_scheduler. Expected values
//            are queued as stimulus is driven and consumed when outputs are
//            sampled 1 time unit after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       sec_tick;
   logic [5:0] time_hh, time_mm, time_ss;
   logic       snooze, dismiss;
   logic       alarm;
   logic [1:0] active_slot;
   logic [1:0] snooze_count;
   logic       missed;

   alarm_scheduler_if #(.SW(2)) cfg_if ();

   alarm_scheduler #(
      .NUM_SLOTS(4), .SNOOZE_MIN(5), .RING_TIMEOUT(60), .MAX_SNOOZE(3)
   ) dut (
      .clk(clk), .reset(reset), .sec_tick(sec_tick),
      .time_hh(time_hh), .time_mm(time_mm), .time_ss(time_ss),
      .cfg(cfg_if.slave), .snooze(snooze), .dismiss(dismiss),
      .alarm(alarm), .active_slot(active_slot),
      .snooze_count(snooze_count), .missed(missed)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cur_h = 0, cur_m = 0, cur_s = 0;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic pop(input logic [31:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%0d", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One idle cycle followed by a one-cycle strobe carrying cur_* time.
   task automatic pulse();
      cyc();
      time_hh  = 6'(cur_h);
      time_mm  = 6'(cur_m);
      time_ss  = 6'(cur_s);
      sec_tick = 1'b1;
      cyc();
      sec_tick = 1'b0;
   endtask

   task automatic tick_at(input int h, input int m, input int s);
      cur_h = h; cur_m = m; cur_s = s;
      pulse();
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) begin
         cur_s++;
         if (cur_s == 60) begin cur_s = 0; cur_m++; end
         if (cur_m == 60) begin cur_m = 0; cur_h++; end
         if (cur_h == 24) cur_h = 0;
         pulse();
      end
   endtask

   task automatic cfg_write(input int slot, input logic en,
                            input int h, input int m, input int s);
      cfg_if.cfg_slot   = 2'(slot);
      cfg_if.cfg_enable = en;
      cfg_if.cfg_hh     = 6'(h);
      cfg_if.cfg_mm     = 6'(m);
      cfg_if.cfg_ss     = 6'(s);
      cfg_if.cfg_valid  = 1'b1;
      cyc();
      cfg_if.cfg_valid  = 1'b0;
   endtask

   task automatic press(input logic d, input logic s);
      dismiss = d;
      snooze  = s;
      cyc();
      dismiss = 1'b0;
      snooze  = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      push({pfx, "_alarm"}, 0);   pop(32'(alarm));
      push({pfx, "_slot"}, 0);    pop(32'(active_slot));
      push({pfx, "_scount"}, 0);  pop(32'(snooze_count));
      push({pfx, "_missed"}, 0);  pop(32'(missed));
      push({pfx, "_cfgerr"}, 0);  pop(32'(cfg_if.cfg_err));
      push({pfx, "_ready"}, 1);   pop(32'(cfg_if.cfg_ready));
   endtask

   initial begin
      reset = 1'b1; sec_tick = 1'b0; snooze = 1'b0; dismiss = 1'b0;
      time_hh = '0; time_mm = '0; time_ss = '0;
      cfg_if.cfg_valid = 1'b0; cfg_if.cfg_slot = '0; cfg_if.cfg_enable = 1'b0;
      cfg_if.cfg_hh = '0; cfg_if.cfg_mm = '0; cfg_if.cfg_ss = '0;
      cyc(); cyc();
      check_reset_vals("rst");
      reset = 1'b0;

      // Basic match and dismiss on slot 1.
      cfg_write(1, 1'b1, 7, 30, 0);
      push("wr_ok_err", 0); pop(32'(cfg_if.cfg_err));
      tick_at(7, 29, 59);
      push("pre_match_alarm", 0); pop(32'(alarm));
      tick_at(7, 30, 0);
      push("match_alarm", 1); pop(32'(alarm));
      push("match_slot", 1);  pop(32'(active_slot));
      press(1'b1, 1'b0);
      push("dismiss_alarm", 0); pop(32'(alarm));

      // Priority: slots 0 and 2 at the same time.
      cfg_write(0, 1'b1, 12, 0, 0);
      cfg_write(2, 1'b1, 12, 0, 0);
      tick_at(12, 0, 0);
      push("prio_alarm", 1); pop(32'(alarm));
      push("prio_slot", 0);  pop(32'(active_slot));
      press(1'b1, 1'b0);
      tick_n(1);
      push("no_retrigger", 0); pop(32'(alarm));

      // Snooze sequence on slot 0.
      cfg_write(0, 1'b1, 6, 0, 0);
      tick_at(6, 0, 0);
      push("sn_ring", 1); pop(32'(alarm));
      press(1'b0, 1'b1);
      push("sn1_alarm", 0);  pop(32'(alarm));
      push("sn1_count", 1);  pop(32'(snooze_count));
      tick_n(299);
      push("sn1_early", 0);  pop(32'(alarm));
      tick_n(1);
      push("sn1_rering", 1); pop(32'(alarm));
      press(1'b0, 1'b1);
      push("sn2_count", 2);  pop(32'(snooze_count));
      tick_n(300);
      push("sn2_rering", 1); pop(32'(alarm));
      press(1'b0, 1'b1);
      push("sn3_count", 3);  pop(32'(snooze_count));
      tick_n(300);
      push("sn3_rering", 1); pop(32'(alarm));
      press(1'b0, 1'b1);
      push("sn4_ignored", 1); pop(32'(alarm));
      push("sn4_count", 3);   pop(32'(snooze_count));
      press(1'b1, 1'b0);
      push("sn_dismiss", 0);  pop(32'(alarm));

      // Ring timeout on slot 1.
      cfg_write(1, 1'b1, 9, 0, 0);
      tick_at(9, 0, 0);
      push("to_ring", 1); pop(32'(alarm));
      tick_n(59);
      push("to_59_alarm", 1);  pop(32'(alarm));
      push("to_59_missed", 0); pop(32'(missed));
      tick_n(1);
      push("to_alarm", 0);  pop(32'(alarm));
      push("to_missed", 1); pop(32'(missed));
      cyc();
      push("to_missed_end", 0); pop(32'(missed));

      // Midnight match, then an out-of-range write must leave the slot intact.
      cfg_write(3, 1'b1, 0, 0, 0);
      tick_at(23, 59, 59);
      push("mid_pre", 0); pop(32'(alarm));
      tick_n(1);
      push("mid_alarm", 1); pop(32'(alarm));
      push("mid_slot", 3);  pop(32'(active_slot));
      press(1'b1, 1'b0);
      cfg_write(3, 1'b0, 24, 0, 0);
      push("bad_err", 1); pop(32'(cfg_if.cfg_err));
      cyc();
      push("bad_err_end", 0); pop(32'(cfg_if.cfg_err));
      tick_at(0, 0, 0);
      push("bad_kept_alarm", 1); pop(32'(alarm));
      push("bad_kept_slot", 3);  pop(32'(active_slot));
      press(1'b1, 1'b0);
      cfg_write(3, 1'b0, 0, 0, 0);

      // Locked slot during ring; other slot writable.
      cfg_write(1, 1'b1, 10, 0, 0);
      tick_at(10, 0, 0);
      push("lk_ring", 1); pop(32'(alarm));
      cfg_if.cfg_slot = 2'd1; cfg_if.cfg_enable = 1'b1;
      cfg_if.cfg_hh = 6'd11; cfg_if.cfg_mm = 6'd0; cfg_if.cfg_ss = 6'd0;
      cfg_if.cfg_valid = 1'b1;
      #1;
      push("lk_ready_busy", 0); pop(32'(cfg_if.cfg_ready));
      cyc();
      cfg_if.cfg_slot = 2'd2; cfg_if.cfg_ss = 6'd5; cfg_if.cfg_hh = 6'd10;
      #1;
      push("lk_ready_other", 1); pop(32'(cfg_if.cfg_ready));
      cyc();
      cfg_if.cfg_valid = 1'b0;
      press(1'b1, 1'b0);
      tick_at(10, 0, 5);
      push("lk_s2_alarm", 1); pop(32'(alarm));
      push("lk_s2_slot", 2);  pop(32'(active_slot));
      press(1'b1, 1'b0);
      tick_at(11, 0, 0);
      push("lk_s1_unchanged", 0); pop(32'(alarm));

      // Snooze passes slot 2's time (dropped), then snooze+dismiss together.
      tick_at(10, 0, 0);
      press(1'b0, 1'b1);
      tick_n(300);
      push("sd_rering", 1); pop(32'(alarm));
      push("sd_slot", 1);   pop(32'(active_slot));
      press(1'b1, 1'b1);
      push("sd_alarm", 0);  pop(32'(alarm));
      push("sd_count", 1);  pop(32'(snooze_count));
      cfg_if.cfg_slot = 2'd1;
      #1;
      push("sd_idle_ready", 1); pop(32'(cfg_if.cfg_ready));
      tick_n(2);
      push("sd_stays_off", 0); pop(32'(alarm));

      // Reset while snoozing.
      tick_at(10, 0, 0);
      press(1'b0, 1'b1);
      push("rs_snoozing", 0); pop(32'(alarm));
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check_reset_vals("rs");
      tick_n(300);
      push("rs_no_rering", 0); pop(32'(alarm));
      tick_at(10, 0, 0);
      push("rs_slots_clear", 0); pop(32'(alarm));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
